// File: rtl/ncl_mult3_sync_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : ncl_mult3_sync_bridge_if
// Brief    : Signal bundle between the synchronous datapath, the bridge and
//            the 3x3 NCL multiplier (operand bus, dual-rail rails, Ki/Ko,
//            product bus and fault status).
// Revision : 1.0 - initial release
// ============================================================================
interface ncl_mult3_sync_bridge_if;
    // Operand side (valid/ready)
    logic [2:0] a_in;
    logic [2:0] b_in;
    logic       in_valid;
    logic       in_ready;
    // Dual-rail operands towards the multiplier
    logic [2:0] ai_rail1;
    logic [2:0] ai_rail0;
    logic [2:0] bi_rail1;
    logic [2:0] bi_rail0;
    // Asynchronous handshake
    logic       ki;
    logic       ko;
    // Dual-rail product from the multiplier
    logic [5:0] po_rail1;
    logic [5:0] po_rail0;
    // Product side (valid/ready)
    logic [5:0] product;
    logic       out_valid;
    logic       out_ready;
    // Fault status
    logic       err;
    logic [1:0] err_code;

    // Environment view: drives operands, multiplier outputs and out_ready
    modport master (
        output a_in, b_in, in_valid, ko, po_rail1, po_rail0, out_ready,
        input  in_ready, ai_rail1, ai_rail0, bi_rail1, bi_rail0, ki,
               product, out_valid, err, err_code
    );

    // Bridge view
    modport slave (
        input  a_in, b_in, in_valid, ko, po_rail1, po_rail0, out_ready,
        output in_ready, ai_rail1, ai_rail0, bi_rail1, bi_rail0, ki,
               product, out_valid, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/ncl_mult3_sync_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ncl_mult3_sync_bridge
// Brief    : Clocked producer/consumer for the 3x3 NCL multiplier. Drives
//            latched binary operands as DATA/NULL dual-rail wavefronts, closes
//            the Ki/Ko handshake, synchronises and checks the dual-rail
//            product and returns it as a binary word.
//            Optional watchdog: define NCL_MULT3_WDOG_EN to bound the time
//            spent in EVAL/FLUSH to WDOG_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ncl_mult3_sync_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int WDOG_CYCLES = 255
) (
    input wire clk,
    input wire rst,
    ncl_mult3_sync_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // ko plus both product rails share one synchroniser word
    localparam int         SYNC_W      = 13;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_WDOG    = 2'd2;

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog_cycles
        $error("WDOG_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0] sync_d [SYNC_STAGES];
    logic [11:0]       po_prev_q, po_prev_d;
    logic [2:0]        a_q, a_d, b_q, b_d;
    logic [2:0]        ai_rail1_q, ai_rail1_d, ai_rail0_q, ai_rail0_d;
    logic [2:0]        bi_rail1_q, bi_rail1_d, bi_rail0_q, bi_rail0_d;
    logic              ki_q, ki_d;
    logic [5:0]        product_q, product_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              ko_s;
    logic [11:0]       po_s;
    logic [5:0]        po_s1, po_s0;
    logic              any_illegal, all_data, all_null;
    logic              data_stable, null_stable;
    logic              in_ready, in_fire, wdog_expired;

    // Synchroniser chain: stage 0 samples the raw asynchronous rails
    always_comb begin
        sync_d[0] = {bus.ko, bus.po_rail1, bus.po_rail0};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops
    always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            if (rst) sync_q[i] <= '0;
            else     sync_q[i] <= sync_d[i];
        end
    end

    assign ko_s  = sync_q[SYNC_STAGES-1][12];
    assign po_s  = sync_q[SYNC_STAGES-1][11:0];
    assign po_s1 = po_s[11:6];
    assign po_s0 = po_s[5:0];

    // Per-bit classification; an illegal bit can never be DATA, so ILLEGAL
    // naturally wins over all_data in the same cycle.
    assign any_illegal = |(po_s1 & po_s0);
    assign all_data    = &(po_s1 ^ po_s0);
    assign all_null    = ~|po_s;
    // Two identical consecutive samples filter skewed or glitching bits
    assign data_stable = all_data && (po_s == po_prev_q);
    assign null_stable = all_null && (po_s == po_prev_q);
    assign po_prev_d   = po_s;

    assign in_ready = (state_q == ST_IDLE) && ko_s && !out_valid_q && !err_q;
    assign in_fire  = bus.in_valid && in_ready;

`ifdef NCL_MULT3_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Cycle counter for EVAL/FLUSH; restarts on every state change
    always_comb begin
        wdog_d = '0;
        if ((state_q == ST_EVAL || state_q == ST_FLUSH) && state_d == state_q) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) wdog_q <= '0;
        else     wdog_q <= wdog_d;
    end

    assign wdog_expired = (state_q == ST_EVAL || state_q == ST_FLUSH) &&
                          (wdog_q == WDOG_W'(WDOG_CYCLES));
`else
    assign wdog_expired = 1'b0;
`endif

    // Next state, operand latch, product capture and fault tracking
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        product_d   = product_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        err_d       = err_q;
        err_code_d  = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (data_stable && !ko_s) begin
                    product_d   = po_s1;
                    out_valid_d = 1'b1;
                    state_d     = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (null_stable && ko_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
        if (state_q != ST_FAULT) begin
            if (any_illegal) begin
                state_d    = ST_FAULT;
                err_d      = 1'b1;
                err_code_d = ERR_ILLEGAL;
            end else if (wdog_expired) begin
                state_d    = ST_FAULT;
                err_d      = 1'b1;
                err_code_d = ERR_WDOG;
            end
        end
    end

    // Rail and Ki drive follow the current state, so they lag it by one cycle
    always_comb begin
        ai_rail1_d = '0;
        ai_rail0_d = '0;
        bi_rail1_d = '0;
        bi_rail0_d = '0;
        ki_d       = 1'b1;
        case (state_q)
            ST_EVAL: begin
                ai_rail1_d = a_q;
                ai_rail0_d = ~a_q;
                bi_rail1_d = b_q;
                bi_rail0_d = ~b_q;
            end
            ST_FLUSH, ST_FAULT: begin
                ki_d = 1'b0;
            end
            default: begin
                ki_d = 1'b1;
            end
        endcase
    end

    // State, operand, rail, output and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            po_prev_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ai_rail1_q  <= '0;
            ai_rail0_q  <= '0;
            bi_rail1_q  <= '0;
            bi_rail0_q  <= '0;
            ki_q        <= 1'b1;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            po_prev_q   <= po_prev_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ai_rail1_q  <= ai_rail1_d;
            ai_rail0_q  <= ai_rail0_d;
            bi_rail1_q  <= bi_rail1_d;
            bi_rail0_q  <= bi_rail0_d;
            ki_q        <= ki_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ai_rail1  = ai_rail1_q;
    assign bus.ai_rail0  = ai_rail0_q;
    assign bus.bi_rail1  = bi_rail1_q;
    assign bus.bi_rail0  = bi_rail0_q;
    assign bus.ki        = ki_q;
    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ncl_mult3_sync_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncl_mult3_sync_bridge
// Brief    : Self-checking bench for ncl_mult3_sync_bridge with a behavioural
//            NCL multiplier model (ideal, delayed, skewed, illegal, stuck).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ncl_mult3_sync_bridge;

    localparam int SYNC_STAGES = 2;
    localparam int WDOG_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ncl_mult3_sync_bridge_if bus();

    ncl_mult3_sync_bridge #(
        .SYNC_STAGES (SYNC_STAGES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [5:0] exp_q [$];

    // Multiplier model control: 0 ideal (+delay), 1 skewed/glitchy,
    // 2 illegal pair on bit 2, 3 stuck (never answers)
    int         mdl_mode  = 0;
    int         mdl_delay = 0;
    int         mdl_step  = 0;
    logic       mdl_done  = 1'b0;
    logic [5:0] mdl_val;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural multiplier: responds just after each clock edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.po_rail1 = '0;
            bus.po_rail0 = '0;
            bus.ko       = 1'b1;
            mdl_step     = 0;
            mdl_done     = 1'b0;
        end else if (!bus.ki && ({bus.ai_rail1, bus.ai_rail0, bus.bi_rail1, bus.bi_rail0} == 12'd0)) begin
            bus.po_rail1 = '0;
            bus.po_rail0 = '0;
            bus.ko       = 1'b1;
            mdl_step     = 0;
            mdl_done     = 1'b0;
        end else if (bus.ki && (&(bus.ai_rail1 ^ bus.ai_rail0)) && (&(bus.bi_rail1 ^ bus.bi_rail0)) && !mdl_done) begin
            mdl_val  = 6'(int'(bus.ai_rail1) * int'(bus.bi_rail1));
            mdl_step = mdl_step + 1;
            case (mdl_mode)
                0: if (mdl_step > mdl_delay) begin
                    bus.po_rail1 = mdl_val;
                    bus.po_rail0 = ~mdl_val;
                    bus.ko       = 1'b0;
                    mdl_done     = 1'b1;
                end
                1: if (mdl_step == 1) begin
                    bus.po_rail1 = mdl_val & 6'b000011;
                    bus.po_rail0 = ~mdl_val & 6'b000011;
                    bus.ko       = 1'b0;
                end else if (mdl_step == 2) begin
                    bus.po_rail1 = mdl_val ^ 6'b100000;
                    bus.po_rail0 = ~(mdl_val ^ 6'b100000);
                end else begin
                    bus.po_rail1 = mdl_val;
                    bus.po_rail0 = ~mdl_val;
                    mdl_done     = 1'b1;
                end
                2: begin
                    bus.po_rail1[2] = 1'b1;
                    bus.po_rail0[2] = 1'b1;
                    mdl_done        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // No rail pair may ever be driven 11
    always @(negedge clk) begin
        if (!rst) begin
            check("rail_pair_11", 16'((bus.ai_rail1 & bus.ai_rail0) | (bus.bi_rail1 & bus.bi_rail0)), 16'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rst_rails", 16'({bus.ai_rail1, bus.ai_rail0, bus.bi_rail1, bus.bi_rail0}), 16'd0);
        check("rst_ki", 16'(bus.ki), 16'd1);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_product", 16'(bus.product), 16'd0);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_err", 16'(bus.err), 16'd0);
        check("rst_err_code", 16'(bus.err_code), 16'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fire_op(input logic [2:0] a, input logic [2:0] b);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 16'(bus.in_ready), 16'd1);
        check("rails_null_at_fire", 16'({bus.ai_rail1, bus.ai_rail0, bus.bi_rail1, bus.bi_rail0}), 16'd0);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(6'(int'(a) * int'(b)));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_in     = 3'($urandom);
        bus.b_in     = 3'($urandom);
    endtask

    task automatic collect(input int hold, input logic chk_lat);
        int         n;
        logic [5:0] exp;
        exp = 6'd0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", 16'(bus.out_valid), 16'd1);
        if (chk_lat) check("latency", 16'(n - 1), 16'd5);
        check("product", 16'(bus.product), 16'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_product_hold", 16'(bus.product), 16'(exp));
            check("bp_out_valid_hold", 16'(bus.out_valid), 16'd1);
            check("bp_in_ready_low", 16'(bus.in_ready), 16'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", 16'(bus.out_valid), 16'd0);
        check("product_kept", 16'(bus.product), 16'(exp));
        if (hold >= 10) check("in_ready_after_drop", 16'(bus.in_ready), 16'd1);
    endtask

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bus.a_in      = 3'd0;
        bus.b_in      = 3'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Directed multiplies, first one with minimum latency
        mdl_mode  = 0;
        mdl_delay = 0;
        fire_op(3'd5, 3'd7); collect(0, 1'b1);
        fire_op(3'd0, 3'd0); collect(0, 1'b0);
        fire_op(3'd7, 3'd7); collect(0, 1'b0);
        fire_op(3'd7, 3'd1); collect(0, 1'b0);

        // Backpressure
        fire_op(3'd3, 3'd6); collect(20, 1'b0);

        // Random operands, multiplier delay and consumer stalls
        for (int i = 0; i < 30; i++) begin
            mdl_delay = int'($urandom_range(0, 4));
            fire_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            collect(int'($urandom_range(0, 3)), 1'b0);
        end

        // Skewed, glitching completion
        mdl_delay = 0;
        mdl_mode  = 1;
        fire_op(3'd6, 3'd5); collect(0, 1'b0);
        mdl_mode  = 0;

        // Illegal rail pair during EVAL
        mdl_mode = 2;
        fire_op(3'd2, 3'd5);
        exp_q.delete();
        n = 0;
        while (bus.err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("illegal_err", 16'(bus.err), 16'd1);
        check("illegal_err_code", 16'(bus.err_code), 16'd1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("fault_in_ready", 16'(bus.in_ready), 16'd0);
            check("fault_err_sticky", 16'(bus.err), 16'd1);
            check("fault_ki", 16'(bus.ki), 16'd0);
        end
        bus.in_valid = 1'b0;
        mdl_mode = 0;
        do_reset();
        fire_op(3'd4, 3'd3); collect(0, 1'b0);

        // Multiplier that never answers
        mdl_mode = 3;
        fire_op(3'd1, 3'd6);
        exp_q.delete();
        repeat (40) @(negedge clk);
`ifdef NCL_MULT3_WDOG_EN
        check("wdog_err", 16'(bus.err), 16'd1);
        check("wdog_err_code", 16'(bus.err_code), 16'd2);
`else
        check("stuck_err", 16'(bus.err), 16'd0);
        check("stuck_err_code", 16'(bus.err_code), 16'd0);
        check("stuck_out_valid", 16'(bus.out_valid), 16'd0);
`endif
        check("stuck_in_ready", 16'(bus.in_ready), 16'd0);
        mdl_mode = 0;
        do_reset();
        fire_op(3'd7, 3'd7); collect(0, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
